pipe_front_regs: RTL

PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

---
 rtl/pipe_front_regs.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipe_front_regs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_front_regs
// Description : Front-end pipeline registers of a 5-stage MIPS-style core.
//               Holds the fetch PC, the IF/ID register and the ID/EX
//               register, with hazard-unit stall/flush controls and
//               saturating stall/flush event counters.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               StallF/StallD       - hold PC / hold IF/ID
//               FlushE              - load a bubble into ID/EX
//               PCSrcD/JumpD        - redirect (branch / jump) from decode
//               PCBranchD/PCJumpD   - redirect targets
//               InstrF              - instruction fetched at PCF
//               CtrlD, RD1D, RD2D, SignImmD, RsD_in, RtD_in, RdD_in
//                                   - decode-stage fields entering ID/EX
//               PCF                 - current fetch address
//               InstrD, PCPlus4D, ValidD - IF/ID contents
//               CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE
//                                   - ID/EX contents
//               StallCnt, FlushCnt  - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic [31:0]      PCBranchD,
    input  logic [31:0]      PCJumpD,
    input  logic [31:0]      InstrF,
    input  logic [7:0]       CtrlD,
    input  logic [31:0]      RD1D,
    input  logic [31:0]      RD2D,
    input  logic [31:0]      SignImmD,
    input  logic [4:0]       RsD_in,
    input  logic [4:0]       RtD_in,
    input  logic [4:0]       RdD_in,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus4D,
    output logic             ValidD,
    output logic             ValidE,
    output logic [7:0]       CtrlE,
    output logic [31:0]      RD1E,
    output logic [31:0]      RD2E,
    output logic [31:0]      SignImmE,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       RdE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [CNT_W-1:0] c_cntMax = {CNT_W{1'b1}};

    logic [31:0]      r_pcF;
    logic [31:0]      r_instrD;
    logic [31:0]      r_pcPlus4D;
    logic             r_validD;
    logic             r_validE;
    logic [7:0]       r_ctrlE;
    logic [31:0]      r_rd1E;
    logic [31:0]      r_rd2E;
    logic [31:0]      r_signImmE;
    logic [4:0]       r_rsE;
    logic [4:0]       r_rtE;
    logic [4:0]       r_rdE;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Natural 32-bit wrap from 32'hFFFF_FFFC back to 0.
    logic [31:0] w_pcPlus4F;
    logic        w_redirectD;

    assign w_pcPlus4F  = r_pcF + 32'd4;
    assign w_redirectD = JumpD | PCSrcD;

    // Fetch PC. A redirect that coincides with StallF is dropped; the hazard
    // unit keeps presenting it until the stall clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcF <= RESET_PC;
        end else if (!StallF) begin
            if (JumpD) begin
                r_pcF <= PCJumpD;
            end else if (PCSrcD) begin
                r_pcF <= PCBranchD;
            end else begin
                r_pcF <= w_pcPlus4F;
            end
        end
    end

    // IF/ID register: stall beats redirect-squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instrD   <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (!StallD) begin
            if (w_redirectD) begin
                r_instrD   <= '0;
                r_pcPlus4D <= '0;
                r_validD   <= 1'b0;
            end else begin
                r_instrD   <= InstrF;
                r_pcPlus4D <= w_pcPlus4F;
                r_validD   <= 1'b1;
            end
        end
    end

    // ID/EX register: never stalls; a flush inserts an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_validE   <= 1'b0;
            r_ctrlE    <= '0;
            r_rd1E     <= '0;
            r_rd2E     <= '0;
            r_signImmE <= '0;
            r_rsE      <= '0;
            r_rtE      <= '0;
            r_rdE      <= '0;
        end else begin
            r_validE   <= r_validD;
            r_ctrlE    <= CtrlD;
            r_rd1E     <= RD1D;
            r_rd2E     <= RD2D;
            r_signImmE <= SignImmD;
            r_rsE      <= RsD_in;
            r_rtE      <= RtD_in;
            r_rdE      <= RdD_in;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (StallD && (r_stallCnt != c_cntMax)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (FlushE && (r_flushCnt != c_cntMax)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign PCF      = r_pcF;
    assign InstrD   = r_instrD;
    assign PCPlus4D = r_pcPlus4D;
    assign ValidD   = r_validD;
    assign ValidE   = r_validE;
    assign CtrlE    = r_ctrlE;
    assign RD1E     = r_rd1E;
    assign RD2E     = r_rd2E;
    assign SignImmE = r_signImmE;
    assign RsE      = r_rsE;
    assign RtE      = r_rtE;
    assign RdE      = r_rdE;
    assign StallCnt = r_stallCnt;
    assign FlushCnt = r_flushCnt;

endmodule
`default_nettype wire
